// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared constants and the stage-register record for
// pipelined_adder.
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth.
//   stage_rec_t            : one stage register at the default geometry.
//                            Fields: valid, partial sum, remaining operands
//                            and carry.
// Optional feature macro: PIPELINED_ADDER_OVERFLOW_EN adds an overflow field.
package pipelined_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Skewed stage record. The low slices of psum are finished sum bits.
  // The high slices of a/b are operand bits that are still waiting for
  // their stage. The top module declares the same layout resized to its
  // own WIDTH.
  typedef struct packed {
    logic                 vld;
    logic [DEF_WIDTH-1:0] psum;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic                 carry;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic                 ovf;
`endif
  } stage_rec_t;

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit add with carry in and carry out.
//   a, b : W-bit operand slices
//   cin  : carry into bit 0 of the slice
//   sum  : W-bit slice sum
//   cout : carry out of bit W-1
module adder_slice
  import pipelined_adder_pkg::*;
#(
  parameter int W = DEF_WIDTH / DEF_STAGES
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep carry-skewed adder with valid/ready handshake.
// Stage k adds operand slice k plus the carry that stage k-1 registered.
//   clk, rst          : clock and asynchronous active-high reset
//   a, b, carry_in    : operands and carry into bit 0
//   in_valid/in_ready : input handshake
//   sum, carry_out    : a + b + carry_in modulo 2^WIDTH, and the carry out
//   out_valid/out_ready : output handshake
//   overflow          : signed overflow of the result. This port exists only
//                       when PIPELINED_ADDER_OVERFLOW_EN is defined.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  // Guard keeps SLICE computable when the geometry check below fails.
  localparam int SLICE = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (STAGES < 1) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be >= 1");
  end else if (WIDTH % STAGES != 0) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  // Same layout as pipelined_adder_pkg::stage_rec_t, resized to WIDTH.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic             ovf;
`endif
  } stage_t;

  // rdy[k]: stage k can take new content this cycle.
  // rdy[STAGES] is the downstream consumer.
  logic [STAGES:0] rdy;
  stage_t          stage_in;

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  always_comb begin
    stage_in       = '0;
    stage_in.vld   = in_valid;
    stage_in.a     = a;
    stage_in.b     = b;
    stage_in.carry = carry_in;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    stage_t           stage_d;
    stage_t           stage_q;
    logic [SLICE-1:0] s_sum;
    logic             s_cout;

    if (k == 0) begin : g_first
      assign src = stage_in;
    end else begin : g_next
      assign src = g_stage[k-1].stage_q;
    end

    adder_slice #(.W(SLICE)) u_slice (
      .a    (src.a[k*SLICE +: SLICE]),
      .b    (src.b[k*SLICE +: SLICE]),
      .cin  (src.carry),
      .sum  (s_sum),
      .cout (s_cout)
    );

    // The slot loads when it is empty or when its occupant leaves this
    // cycle. Loading an invalid upstream entry is what collapses bubbles.
    assign rdy[k] = !stage_q.vld || rdy[k+1];

    always_comb begin
      stage_d = stage_q;
      if (rdy[k]) begin
        stage_d                         = src;
        stage_d.psum[k*SLICE +: SLICE]  = s_sum;
        stage_d.carry                   = s_cout;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        // The carry into the MSB is recovered as a^b^sum at the MSB.
        if (k == STAGES - 1)
          stage_d.ovf = src.a[WIDTH-1] ^ src.b[WIDTH-1] ^ s_sum[SLICE-1] ^ s_cout;
`endif
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) stage_q <= '0;
      else     stage_q <= stage_d;
    end
  end

  assign out_valid = g_stage[STAGES-1].stage_q.vld;
  assign sum       = g_stage[STAGES-1].stage_q.psum;
  assign carry_out = g_stage[STAGES-1].stage_q.carry;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  assign overflow  = g_stage[STAGES-1].stage_q.ovf;
`endif

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter STAGES, default 4: pipeline stages; WIDTH SHALL be an integer multiple of STAGES; SLICE = WIDTH/STAGES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 carry_in  input  1  carry into bit 0.
REQ-008 in_valid  input  1  a/b/carry_in valid this cycle.
REQ-009 in_ready  output  1  block accepts input this cycle.
REQ-010 sum  output  WIDTH  result a+b+carry_in, modulo 2^WIDTH.
REQ-011 carry_out  output  1  carry out of bit WIDTH-1.
REQ-012 out_valid  output  1  sum/carry_out hold a valid result.
REQ-013 out_ready  input  1  consumer accepts result this cycle.

Function
REQ-014 Stage k (0..STAGES-1) SHALL add operand bits [k*SLICE +: SLICE] plus the carry registered by stage k-1 (stage 0 uses carry_in).
- Unprocessed operand bits and completed sum bits SHALL be carried forward in stage registers (skewed datapath).
REQ-015 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-016 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no backpressure.
REQ-017 Throughput SHALL be one transaction per cycle while out_ready is held high.
REQ-018 Each stage has a valid bit; stage k SHALL load when its slot is empty or its content moves downstream in the same cycle (per-stage ready = !valid_k || ready_{k+1}; ready after last stage = out_ready).
REQ-019 in_ready SHALL equal stage-0 ready; bubbles SHALL collapse under backpressure.
REQ-020 A stalled stage SHALL hold its data and valid unchanged; no transaction SHALL be dropped, duplicated or reordered.
REQ-021 sum, carry_out SHALL be stable while out_valid && !out_ready.
REQ-022 Simultaneous input and output transfer on a full pipeline SHALL be accepted in the same cycle.
REQ-023 Inputs while in_ready is low SHALL be ignored.

Reset
REQ-024 On rst asserted, all stage valid bits, out_valid, sum, carry_out (and overflow) SHALL go to 0 immediately, independent of clk.
REQ-025 In-flight transactions at reset SHALL be discarded; in_ready SHALL be 1 the first cycle after rst deasserts.

Configuration
REQ-026 Macro PIPELINED_ADDER_OVERFLOW_EN defined: output port overflow (1 bit) SHALL exist, valid with out_valid, equal to signed two's-complement overflow (carry into MSB XOR carry out of MSB).
REQ-027 Macro undefined: overflow port and its pipeline state SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package pipelined_adder_pkg SHALL hold default WIDTH/STAGES constants and the stage-register record typedef (valid, partial sum, remaining operands, carry).
REQ-029 One sub-module adder_slice SHALL implement a combinational SLICE-bit add with carry in/out, instantiated once per stage.
REQ-030 Elaboration SHALL fail if WIDTH % STAGES != 0 or STAGES < 1.

Verification (WIDTH=16, STAGES=4)
REQ-031 a=0xFFFF, b=0x0001, carry_in=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x0000, carry_out=1.
REQ-032 Back-to-back inputs (0x1234+0x1111), (0x00FF+0x0001 cin=1), (0x8000+0x8000) -> consecutive outputs 0x2345/0, 0x0101/0, 0x0000/1 in order.
REQ-033 Stream 8 inputs, out_ready=0 for 6 cycles -> in_ready drops after 4 accepted, held output stable, all 8 results delivered in order when out_ready returns.
REQ-034 rst pulsed with 3 transactions in flight -> out_valid=0 immediately; no stale result appears afterwards; next input yields correct result after 4 cycles.
REQ-035 With PIPELINED_ADDER_OVERFLOW_EN: 0x7FFF+0x0001 -> sum=0x8000, overflow=1; 0xFFFF+0x0001 -> overflow=0, carry_out=1.
